tinyml_hw_accel_dma_bridge: RTL and testbench

- Frame-oriented streaming bridge between the DMA read/write channels and a pixel-serial TinyML hardware accelerator pipeline.
- Unpacks wide DMA beats into PIX_WIDTH pixels and feeds the accelerator.
- Packs accelerator results back into DMA beats, with programmable burst length and a programmable frame length.
- Backpressure is credit-based, so the output buffer cannot overflow regardless of accelerator pipeline depth. Each frame is bracketed by a start/done handshake and an accelerator clear pulse.

---
 rtl/tinyml_hw_accel_dma_bridge.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_tinyml_hw_accel_dma_bridge.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tinyml_hw_accel_dma_bridge.sv
// Frame bridge: unpacks DMA read beats into accelerator pixels and packs results into DMA write bursts.
// Latency: first acc_in_valid 2 cycles after a read beat is accepted; write beat registered after its last pixel.
// Backpressure: read side stalls on a full input FIFO, pixel issue stalls on credits, write side holds until dma_wready.

module tinyml_hw_accel_dma_bridge_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    // Generic first-word-fall-through FIFO, depth a power of 2.
    // Latency: written entry visible at the head on the next cycle.
    // Backpressure: push while full and pop while empty are ignored.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop_dat = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[AW-1:0]] <= push_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + 1'b1;
            if (pop && !empty) rptr <= rptr + 1'b1;
        end
    end
endmodule

module tinyml_hw_accel_dma_bridge #(
    parameter int DMA_WIDTH = 128,
    parameter int PIX_WIDTH = 32,
    parameter int IN_DEPTH  = 64,
    parameter int OUT_DEPTH = 256,
    parameter int LEN_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LEN_WIDTH-1:0]   frame_pixels,
    input  logic [15:0]            burst_beats,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   acc_clear,
    output logic                   dma_rready,
    input  logic                   dma_rvalid,
    input  logic [DMA_WIDTH/8-1:0] dma_rkeep,
    input  logic [DMA_WIDTH-1:0]   dma_rdata,
    output logic [PIX_WIDTH-1:0]   acc_in_data,
    output logic                   acc_in_valid,
    input  logic [PIX_WIDTH-1:0]   acc_out_data,
    input  logic                   acc_out_valid,
    input  logic                   dma_wready,
    output logic                   dma_wvalid,
    output logic                   dma_wlast,
    output logic [DMA_WIDTH-1:0]   dma_wdata,
    output logic [3:0]             status,
    output logic [31:0]            in_pixels,
    output logic [31:0]            out_pixels
);
    // Pixel-serial TinyML bridge: read beats -> pixels -> accelerator -> pixels -> write bursts.
    // Latency: read beat to first pixel 2 cycles; frame ends when the beat holding the final pixel is accepted.
    // Backpressure: credits cover every pixel from issue until its write beat is accepted, so nothing overflows.
    localparam int LANES = DMA_WIDTH / PIX_WIDTH;
    localparam int KW    = DMA_WIDTH / 8;
    localparam int PB    = PIX_WIDTH / 8;
    localparam int LIW   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int LCW   = $clog2(LANES + 1);
    localparam int CW    = $clog2(OUT_DEPTH + 1);
    localparam int CW1   = CW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    logic [LEN_WIDTH-1:0]   frame_len;
    logic [15:0]            burst_len;
    logic [15:0]            burst_cnt;
    logic [CW-1:0]          credits;
    logic [LIW-1:0]         lane_idx;
    logic [DMA_WIDTH-1:0]   asm_dat;
    logic [LCW-1:0]         asm_cnt;
    logic                   asm_done;
    logic                   asm_fin;
    logic [LCW-1:0]         wcnt;
    logic                   wfin;

    logic                   flush;
    logic                   in_push, in_pop, in_full, in_empty, in_ovf;
    logic [KW+DMA_WIDTH-1:0] in_head;
    logic                   of_push, of_pop, of_full, of_empty, of_ovf, unexp;
    logic [PIX_WIDTH-1:0]   of_head;

    assign flush      = (state == DONE);
    assign dma_rready = (state == RUN) && !in_full;
    assign in_push    = dma_rvalid && dma_rready;
    assign in_ovf     = in_push && in_full;
    assign of_push    = acc_out_valid && (state == RUN);
    assign of_ovf     = of_push && of_full;
    assign unexp      = acc_out_valid && (state != RUN);

    tinyml_hw_accel_dma_bridge_fifo #(.W(KW + DMA_WIDTH), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk(clk), .rst(rst), .clr(flush),
        .push(in_push), .push_dat({dma_rkeep, dma_rdata}),
        .pop(in_pop), .pop_dat(in_head), .full(in_full), .empty(in_empty)
    );

    tinyml_hw_accel_dma_bridge_fifo #(.W(PIX_WIDTH), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk(clk), .rst(rst), .clr(flush),
        .push(of_push), .push_dat(acc_out_data),
        .pop(of_pop), .pop_dat(of_head), .full(of_full), .empty(of_empty)
    );

    // Unpacker walks the lanes of the input FIFO head; the beat is popped after its last lane.
    logic [PIX_WIDTH-1:0] lane_pix;
    logic                 keep_ok, issue, advance, skip;

    always_comb begin
        lane_pix = '0;
        keep_ok  = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_idx == LIW'(i)) begin
                lane_pix = in_head[i*PIX_WIDTH +: PIX_WIDTH];
                keep_ok  = &in_head[DMA_WIDTH + i*PB +: PB];
            end
        end
        issue   = 1'b0;
        advance = 1'b0;
        skip    = 1'b0;
        if (state == RUN && !in_empty) begin
            if (!keep_ok) begin
                skip    = 1'b1;
                advance = 1'b1;
            end else if (in_pixels >= 32'(frame_len)) begin
                advance = 1'b1;
            end else if (credits != '0) begin
                issue   = 1'b1;
                advance = 1'b1;
            end
        end
    end

    assign in_pop = advance && (lane_idx == LIW'(LANES - 1));

    // Packer: a completed word moves to the write register whenever that register is free this cycle.
    logic                 out_acc, out_free, xfer, last_pix, burst_hit;
    logic [DMA_WIDTH-1:0] base_dat, nxt_dat;
    logic [LCW-1:0]       base_cnt, nxt_cnt, cred_ret;
    logic                 base_done, nxt_done, nxt_fin;
    logic [CW1-1:0]       csum;
    logic [CW-1:0]        cred_nxt;

    assign out_acc   = dma_wvalid && dma_wready;
    assign out_free  = !dma_wvalid || dma_wready;
    assign xfer      = asm_done && out_free;
    assign last_pix  = (out_pixels == 32'(frame_len) - 32'd1);
    assign burst_hit = (burst_cnt + 16'd1 == burst_len);

    always_comb begin
        base_dat  = xfer ? '0 : asm_dat;
        base_cnt  = xfer ? '0 : asm_cnt;
        base_done = xfer ? 1'b0 : asm_done;
        nxt_fin   = xfer ? 1'b0 : asm_fin;
        of_pop    = (state == RUN) && !of_empty && !base_done;
        nxt_dat   = base_dat;
        nxt_cnt   = base_cnt;
        nxt_done  = base_done;
        if (of_pop) begin
            for (int i = 0; i < LANES; i++) begin
                if (base_cnt == LCW'(i)) nxt_dat[i*PIX_WIDTH +: PIX_WIDTH] = of_head;
            end
            nxt_cnt  = base_cnt + LCW'(1);
            nxt_done = (base_cnt == LCW'(LANES - 1)) || last_pix;
            nxt_fin  = last_pix;
        end
    end

    // Credits return when the pixels leave the bridge inside an accepted write beat.
    always_comb begin
        cred_ret = out_acc ? wcnt : '0;
        csum     = {1'b0, credits} + CW1'(cred_ret) - CW1'(issue);
        cred_nxt = (csum > CW1'(OUT_DEPTH)) ? CW'(OUT_DEPTH) : csum[CW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            acc_clear    <= 1'b0;
            frame_len    <= '0;
            burst_len    <= 16'd1;
            burst_cnt    <= '0;
            credits      <= CW'(OUT_DEPTH);
            lane_idx     <= '0;
            acc_in_valid <= 1'b0;
            acc_in_data  <= '0;
            asm_dat      <= '0;
            asm_cnt      <= '0;
            asm_done     <= 1'b0;
            asm_fin      <= 1'b0;
            dma_wvalid   <= 1'b0;
            dma_wlast    <= 1'b0;
            dma_wdata    <= '0;
            wfin         <= 1'b0;
            wcnt         <= '0;
            status       <= '0;
            in_pixels    <= '0;
            out_pixels   <= '0;
        end else begin
            frame_done   <= 1'b0;
            acc_clear    <= 1'b0;
            acc_in_valid <= issue;
            if (issue) acc_in_data <= lane_pix;
            status  <= status | {skip, of_ovf, in_ovf, unexp};
            credits <= cred_nxt;
            if (advance) lane_idx <= (lane_idx == LIW'(LANES - 1)) ? '0 : lane_idx + LIW'(1);
            if (issue && in_pixels != '1) in_pixels <= in_pixels + 32'd1;
            if (of_pop && out_pixels != '1) out_pixels <= out_pixels + 32'd1;
            asm_dat  <= nxt_dat;
            asm_cnt  <= nxt_cnt;
            asm_done <= nxt_done;
            asm_fin  <= nxt_fin;
            if (xfer) begin
                dma_wvalid <= 1'b1;
                dma_wdata  <= asm_dat;
                dma_wlast  <= burst_hit || asm_fin;
                wfin       <= asm_fin;
                wcnt       <= asm_cnt;
                burst_cnt  <= (burst_hit || asm_fin) ? 16'd0 : burst_cnt + 16'd1;
            end else if (out_acc) begin
                dma_wvalid <= 1'b0;
                dma_wlast  <= 1'b0;
                wfin       <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        frame_len  <= frame_pixels;
                        burst_len  <= (burst_beats == 16'd0) ? 16'd1 : burst_beats;
                        burst_cnt  <= '0;
                        in_pixels  <= '0;
                        out_pixels <= '0;
                    end
                end
                RUN: begin
                    if (frame_len == '0 || (out_acc && wfin)) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                        acc_clear  <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    credits    <= CW'(OUT_DEPTH);
                    lane_idx   <= '0;
                    asm_dat    <= '0;
                    asm_cnt    <= '0;
                    asm_done   <= 1'b0;
                    asm_fin    <= 1'b0;
                    dma_wvalid <= 1'b0;
                    dma_wlast  <= 1'b0;
                    wfin       <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tinyml_hw_accel_dma_bridge.sv
// Directed bench for the DMA bridge with an identity accelerator of 3-cycle latency.
module tb_tinyml_hw_accel_dma_bridge;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [23:0]  frame_pixels;
    logic [15:0]  burst_beats;
    logic         busy, frame_done, acc_clear, dma_rready;
    logic         dma_rvalid;
    logic [15:0]  dma_rkeep;
    logic [127:0] dma_rdata;
    logic [31:0]  acc_in_data, acc_out_data;
    logic         acc_in_valid, acc_out_valid;
    logic         dma_wready, dma_wvalid, dma_wlast;
    logic [127:0] dma_wdata;
    logic [3:0]   status;
    logic [31:0]  in_pixels, out_pixels;

    typedef struct { logic [127:0] d; logic [15:0] k; } rbeat_t;
    typedef struct { logic [127:0] d; logic l; } wbeat_t;
    rbeat_t rd_q[$];
    wbeat_t got_q[$];
    wbeat_t exp_q[$];

    int n_chk = 0;
    int n_err = 0;
    int issue_cnt = 0;
    int done_cnt = 0;
    logic took;
    logic [2:0]  pv;
    logic [31:0] pd0, pd1, pd2;

    always #5 clk = ~clk;

    tinyml_hw_accel_dma_bridge #(
        .DMA_WIDTH(128), .PIX_WIDTH(32), .IN_DEPTH(4), .OUT_DEPTH(8), .LEN_WIDTH(24)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .frame_pixels(frame_pixels),
        .burst_beats(burst_beats), .busy(busy), .frame_done(frame_done),
        .acc_clear(acc_clear), .dma_rready(dma_rready), .dma_rvalid(dma_rvalid),
        .dma_rkeep(dma_rkeep), .dma_rdata(dma_rdata), .acc_in_data(acc_in_data),
        .acc_in_valid(acc_in_valid), .acc_out_data(acc_out_data),
        .acc_out_valid(acc_out_valid), .dma_wready(dma_wready),
        .dma_wvalid(dma_wvalid), .dma_wlast(dma_wlast), .dma_wdata(dma_wdata),
        .status(status), .in_pixels(in_pixels), .out_pixels(out_pixels)
    );

    // Identity accelerator, three cycles deep, cleared by the shared reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0; pd0 <= '0; pd1 <= '0; pd2 <= '0;
        end else begin
            pv <= {pv[1:0], acc_in_valid};
            pd0 <= acc_in_data; pd1 <= pd0; pd2 <= pd1;
        end
    end
    assign acc_out_valid = pv[2];
    assign acc_out_data  = pd2;

    // Read-channel driver: presents the head of rd_q until it is accepted.
    initial begin
        dma_rvalid = 1'b0; dma_rdata = '0; dma_rkeep = '0;
        forever begin
            @(negedge clk);
            took = dma_rvalid && dma_rready;
            @(posedge clk); #1;
            if (took && rd_q.size() > 0) void'(rd_q.pop_front());
            if (rd_q.size() > 0 && !rst) begin
                dma_rvalid = 1'b1; dma_rdata = rd_q[0].d; dma_rkeep = rd_q[0].k;
            end else begin
                dma_rvalid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (dma_wvalid && dma_wready) got_q.push_back('{d: dma_wdata, l: dma_wlast});
        if (acc_in_valid) issue_cnt++;
        if (frame_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk_beat(input int b);
        return {32'(b + 3), 32'(b + 2), 32'(b + 1), 32'(b)};
    endfunction

    task automatic push_beats(input int n);
        for (int b = 0; b < n; b++) rd_q.push_back('{d: mk_beat(4 * b), k: 16'hFFFF});
    endtask

    task automatic exp_add(input logic [127:0] d, input logic l);
        exp_q.push_back('{d: d, l: l});
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; dma_wready = 1'b0;
        repeat (2) @(posedge clk); #1;
        rd_q.delete(); got_q.delete(); exp_q.delete();
        issue_cnt = 0; done_cnt = 0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic start_frame(input int len, input int bl);
        frame_pixels = 24'(len); burst_beats = 16'(bl); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (done_cnt < 1 && t < 2000) begin
            @(negedge clk); #1; t++;
        end
        check({tag, "_done_seen"}, 128'(done_cnt >= 1), 128'(1));
        repeat (4) @(posedge clk); #1;
        check({tag, "_done_once"}, 128'(done_cnt), 128'(1));
    endtask

    task automatic cmp_out(input string tag);
        check({tag, "_nbeats"}, 128'(got_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), got_q[i].d, exp_q[i].d);
            check($sformatf("%s_last%0d", tag, i), 128'(got_q[i].l), 128'(exp_q[i].l));
        end
    endtask

    initial begin
        int t;
        frame_pixels = '0; burst_beats = '0;
        do_reset();
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_rready", 128'(dma_rready), 128'(0));
        check("rst_wvalid", 128'(dma_wvalid), 128'(0));
        check("rst_accvalid", 128'(acc_in_valid), 128'(0));
        check("rst_fdone", 128'({frame_done, acc_clear}), 128'(0));
        check("rst_status", 128'(status), 128'(0));
        check("rst_counts", 128'({in_pixels, out_pixels}), 128'(0));

        // 16-pixel frame, bursts of 2
        push_beats(4); dma_wready = 1'b1;
        start_frame(16, 2);
        wait_done("f16");
        exp_add(mk_beat(0), 0); exp_add(mk_beat(4), 1);
        exp_add(mk_beat(8), 0); exp_add(mk_beat(12), 1);
        cmp_out("f16");
        check("f16_inpix", 128'(in_pixels), 128'(16));
        check("f16_outpix", 128'(out_pixels), 128'(16));
        check("f16_status", 128'(status), 128'(0));
        check("f16_busy", 128'(busy), 128'(0));

        // 10-pixel frame: partial last beat zero-padded, surplus input discarded
        do_reset();
        push_beats(4); dma_wready = 1'b1;
        start_frame(10, 2);
        wait_done("f10");
        exp_add(mk_beat(0), 0); exp_add(mk_beat(4), 1);
        exp_add({64'd0, 32'd9, 32'd8}, 1);
        cmp_out("f10");
        check("f10_inpix", 128'(in_pixels), 128'(10));
        check("f10_outpix", 128'(out_pixels), 128'(10));

        // Lane 3 of the first beat has partial keep; burst_beats 0 behaves as 1
        do_reset();
        rd_q.push_back('{d: mk_beat(0), k: 16'h0FFF});
        rd_q.push_back('{d: mk_beat(4), k: 16'hFFFF});
        dma_wready = 1'b1;
        start_frame(7, 0);
        wait_done("keep");
        exp_add({32'd4, 32'd2, 32'd1, 32'd0}, 1);
        exp_add({32'd0, 32'd7, 32'd6, 32'd5}, 1);
        cmp_out("keep");
        check("keep_status", 128'(status), 128'(4'b1000));

        // Write channel stalled: credit limit and full input FIFO
        do_reset();
        push_beats(6); dma_wready = 1'b0;
        start_frame(16, 4);
        repeat (200) @(posedge clk); #1;
        check("bp_issued", 128'(issue_cnt), 128'(8));
        check("bp_rready", 128'(dma_rready), 128'(0));
        check("bp_rd_drained", 128'(rd_q.size()), 128'(0));
        check("bp_wvalid_held", 128'(dma_wvalid), 128'(1));
        check("bp_wdata_held", dma_wdata, mk_beat(0));
        check("bp_status_mid", 128'(status), 128'(0));
        dma_wready = 1'b1;
        wait_done("bp");
        exp_add(mk_beat(0), 0); exp_add(mk_beat(4), 0);
        exp_add(mk_beat(8), 0); exp_add(mk_beat(12), 1);
        cmp_out("bp");
        check("bp_status_end", 128'(status), 128'(0));
        check("bp_inpix", 128'(in_pixels), 128'(16));

        // Reset in the middle of a frame, then a clean frame
        do_reset();
        push_beats(4); dma_wready = 1'b1;
        start_frame(16, 2);
        t = 0;
        while (issue_cnt < 7 && t < 500) begin
            @(negedge clk); #1; t++;
        end
        check("rstmid_reach7", 128'(issue_cnt >= 7), 128'(1));
        do_reset();
        repeat (10) @(posedge clk); #1;
        check("rstmid_no_done", 128'(done_cnt), 128'(0));
        check("rstmid_busy", 128'(busy), 128'(0));
        check("rstmid_status", 128'(status), 128'(0));
        push_beats(4); dma_wready = 1'b1;
        start_frame(16, 2);
        wait_done("rstmid2");
        exp_add(mk_beat(0), 0); exp_add(mk_beat(4), 1);
        exp_add(mk_beat(8), 0); exp_add(mk_beat(12), 1);
        cmp_out("rstmid2");
        check("rstmid2_status", 128'(status), 128'(0));

        // start pulses during RUN are ignored
        do_reset();
        push_beats(2); dma_wready = 1'b0;
        start_frame(8, 2);
        repeat (20) @(posedge clk); #1;
        start_frame(3, 1);
        repeat (5) @(posedge clk); #1;
        dma_wready = 1'b1;
        wait_done("midstart");
        exp_add(mk_beat(0), 0); exp_add(mk_beat(4), 1);
        cmp_out("midstart");
        check("midstart_inpix", 128'(in_pixels), 128'(8));

        // Zero-length frame: frame_done two cycles after start, no writes
        do_reset();
        dma_wready = 1'b1;
        frame_pixels = '0; burst_beats = 16'd2; start = 1'b1;
        @(negedge clk);
        check("zero_fd_c0", 128'(frame_done), 128'(0));
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        check("zero_fd_c1", 128'({busy, frame_done}), 128'(2'b10));
        @(negedge clk);
        check("zero_fd_c2", 128'({frame_done, acc_clear}), 128'(2'b11));
        @(negedge clk);
        check("zero_fd_c3", 128'({busy, frame_done}), 128'(0));
        repeat (5) @(posedge clk); #1;
        check("zero_nwrites", 128'(got_q.size()), 128'(0));
        check("zero_done_once", 128'(done_cnt), 128'(1));
        check("zero_outpix", 128'(out_pixels), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
